// File: rtl/nano_dphy_pkg.sv
// Shared D-PHY receive definitions: LP line codes and clock-lane receiver states.
// No ports. Imported by nano_dphy_lp_filt and nano_dsi_clk_rx.
package nano_dphy_pkg;

  // Line codes are {dp, dn}.
  localparam logic [1:0] LP11 = 2'b11;
  localparam logic [1:0] LP01 = 2'b01;
  localparam logic [1:0] LP10 = 2'b10;
  localparam logic [1:0] LP00 = 2'b00;

  typedef enum logic [2:0] {
    ST_STOP    = 3'd0,
    ST_HS_RQST = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_HS      = 3'd3,
    ST_ERR     = 3'd4
  } clk_rx_state_e;

endpackage

// File: rtl/nano_dphy_lp_filt.sv
// Two-line LP input conditioner: a 2-flop synchronizer per line followed by a
// run-length glitch filter. The filtered state only follows the synchronized
// state after it has been stable for FILT_LEN consecutive samples.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   lp_dp_i, lp_dn_i   raw comparator outputs (asynchronous to clk)
//   lp_f_o             filtered {dp,dn}; LP-11 out of reset
module nano_dphy_lp_filt
  import nano_dphy_pkg::*;
#(
  parameter int FILT_LEN = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lp_dp_i,
  input  logic       lp_dn_i,
  output logic [1:0] lp_f_o
);

  logic [1:0] lp_raw;
  logic [1:0] lp_s;
  logic [1:0] last_q;
  logic [3:0] run_q;
  logic [3:0] run_d;
  logic [1:0] lp_f_q;

  assign lp_raw = {lp_dp_i, lp_dn_i};

  // Each line gets its own synchronizer; idle level is high on both lines.
  for (genvar gi = 0; gi < 2; gi++) begin : g_sync
    logic meta_q;
    logic sync_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        meta_q <= 1'b1;
        sync_q <= 1'b1;
      end else begin
        meta_q <= lp_raw[gi];
        sync_q <= meta_q;
      end
    end
    assign lp_s[gi] = sync_q;
  end

  // run_d is the length of the current run including this sample. It
  // saturates at FILT_LEN so the counter never wraps during long holds.
  always_comb begin
    run_d = 4'd1;
    if (lp_s == last_q) begin
      run_d = (run_q >= 4'(FILT_LEN)) ? run_q : run_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= LP11;
      run_q  <= 4'd0;
      lp_f_q <= LP11;
    end else begin
      last_q <= lp_s;
      run_q  <= run_d;
      if (run_d >= 4'(FILT_LEN)) begin
        lp_f_q <= lp_s;
      end
    end
  end

  assign lp_f_o = lp_f_q;

endmodule

// File: rtl/nano_dsi_clk_rx.sv
// D-PHY clock-lane receive controller. Tracks LP-11 -> LP-01 -> LP-00 -> HS
// and the return to LP-11, drives HS termination and the HS-valid flag for the
// data lanes, and pulses on sequence violations and request timeouts.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   lp_dp, lp_dn               raw LP comparator inputs
//   cfg_settle                 LP-00 settle load value (N -> N+1 cycles)
//   cfg_rqst_max               maximum LP-01 load value (N -> N+1 cycles)
//   hs_term_en, hs_active      termination enable, HS clock valid
//   hs_start, hs_end           one-cycle pulses on HS entry / HS exit to stop
//   stop_state, lp_state       lane in LP-11 stop, filtered {dp,dn}
//   err_seq, err_timeout       one-cycle error pulses
module nano_dsi_clk_rx
  import nano_dphy_pkg::*;
#(
  parameter int FILT_LEN = 2,
  parameter int TIMER_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               lp_dp,
  input  logic               lp_dn,
  input  logic [TIMER_W-2:0] cfg_settle,
  input  logic [TIMER_W-2:0] cfg_rqst_max,
  output logic               hs_term_en,
  output logic               hs_active,
  output logic               hs_start,
  output logic               hs_end,
  output logic               stop_state,
  output logic [1:0]         lp_state,
  output logic               err_seq,
  output logic               err_timeout
);

  logic [1:0]         lp_f;
  clk_rx_state_e      state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d, timer_dec;
  logic               trig;
  logic               load_rqst, load_settle;
  logic               seq_d, to_d;
  logic               seq_evt_q, to_evt_q;
  logic               hs_term_en_q, hs_active_q, hs_start_q, hs_end_q;
  logic               stop_state_q, err_seq_q, err_timeout_q;

  nano_dphy_lp_filt #(
    .FILT_LEN (FILT_LEN)
  ) u_lp_filt (
    .clk     (clk),
    .rst_n   (rst_n),
    .lp_dp_i (lp_dp),
    .lp_dn_i (lp_dn),
    .lp_f_o  (lp_f)
  );

  // Trigger is the MSB of the decremented value: it goes high in the cycle the
  // counter underflows, so the state is left exactly N+1 cycles after entry.
  assign timer_dec = timer_q - TIMER_W'(1);
  assign trig      = timer_dec[TIMER_W-1];

  always_comb begin
    state_d     = state_q;
    load_rqst   = 1'b0;
    load_settle = 1'b0;
    seq_d       = 1'b0;
    to_d        = 1'b0;
    case (state_q)
      ST_STOP: begin
        if (lp_f == LP01) begin
          state_d   = ST_HS_RQST;
          load_rqst = 1'b1;
        end else if (lp_f != LP11) begin
          state_d = ST_ERR;
          seq_d   = 1'b1;
        end
      end
      ST_HS_RQST: begin
        // A line change wins over a timeout landing in the same cycle.
        if (lp_f == LP00) begin
          state_d     = ST_SETTLE;
          load_settle = 1'b1;
        end else if (lp_f == LP11) begin
          state_d = ST_STOP;
        end else if (lp_f == LP10) begin
          state_d = ST_ERR;
          seq_d   = 1'b1;
        end else if (trig) begin
          state_d = ST_ERR;
          to_d    = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (trig) begin
          state_d = ST_HS;
        end else if (lp_f != LP00) begin
          state_d = ST_ERR;
          seq_d   = 1'b1;
        end
      end
      ST_HS: begin
        // HS swing looks like LP-00 to the comparators, so 00 is normal here.
        if (lp_f == LP11) begin
          state_d = ST_STOP;
        end else if (lp_f != LP00) begin
          state_d = ST_ERR;
          seq_d   = 1'b1;
        end
      end
      ST_ERR: begin
        if (lp_f == LP11) begin
          state_d = ST_STOP;
        end
      end
      default: state_d = ST_STOP;
    endcase
  end

  always_comb begin
    timer_d = timer_dec;
    if (load_rqst) begin
      timer_d = {1'b0, cfg_rqst_max};
    end else if (load_settle) begin
      timer_d = {1'b0, cfg_settle};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_STOP;
      timer_q   <= '0;
      seq_evt_q <= 1'b0;
      to_evt_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      seq_evt_q <= seq_d;
      to_evt_q  <= to_d;
    end
  end

  // Outputs are one register stage behind the state. hs_active_q holds the
  // previous state's HS flag, which gives the entry/exit edges for the pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_term_en_q  <= 1'b0;
      hs_active_q   <= 1'b0;
      hs_start_q    <= 1'b0;
      hs_end_q      <= 1'b0;
      stop_state_q  <= 1'b1;
      err_seq_q     <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      hs_term_en_q  <= (state_q == ST_SETTLE) || (state_q == ST_HS);
      hs_active_q   <= (state_q == ST_HS);
      hs_start_q    <= (state_q == ST_HS) && !hs_active_q;
      hs_end_q      <= (state_q == ST_STOP) && hs_active_q;
      stop_state_q  <= (state_q == ST_STOP);
      err_seq_q     <= seq_evt_q;
      err_timeout_q <= to_evt_q;
    end
  end

  assign hs_term_en  = hs_term_en_q;
  assign hs_active   = hs_active_q;
  assign hs_start    = hs_start_q;
  assign hs_end      = hs_end_q;
  assign stop_state  = stop_state_q;
  assign lp_state    = lp_f;
  assign err_seq     = err_seq_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_nano_dsi_clk_rx.sv
module tb_nano_dsi_clk_rx;
  localparam int F       = 2;
  localparam int TW      = 8;
  localparam int MAXC    = 8192;
  localparam int REL_INF = 32'h3fff_ffff;
  localparam int M_STOP = 0, M_RQST = 1, M_SETTLE = 2, M_HS = 3, M_ERR = 4;
  localparam int E_NONE = 0, E_START = 1, E_END = 2, E_SEQ = 3, E_TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic lp_dp = 1'b1;
  logic lp_dn = 1'b1;
  logic [TW-2:0] cfg_settle = 7'd5;
  logic [TW-2:0] cfg_rqst_max = 7'd20;
  logic hs_term_en, hs_active, hs_start, hs_end, stop_state, err_seq, err_timeout;
  logic [1:0] lp_state;

  nano_dsi_clk_rx #(.FILT_LEN(F), .TIMER_W(TW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lp_dp        (lp_dp),
    .lp_dn        (lp_dn),
    .cfg_settle   (cfg_settle),
    .cfg_rqst_max (cfg_rqst_max),
    .hs_term_en   (hs_term_en),
    .hs_active    (hs_active),
    .hs_start     (hs_start),
    .hs_end       (hs_end),
    .stop_state   (stop_state),
    .lp_state     (lp_state),
    .err_seq      (err_seq),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Expected output vector per cycle:
  // {hs_term_en, hs_active, hs_start, hs_end, stop_state, lp_state[1:0], err_seq, err_timeout}
  typedef struct {
    int         c;
    logic [8:0] v;
  } exp_t;
  exp_t exp_q[$];

  // Reference model history, indexed by cycle number.
  logic [1:0]    pa[MAXC];
  logic [1:0]    sa[MAXC];
  logic [1:0]    fa[MAXC];
  int            sta[MAXC];
  int            eva[MAXC];
  logic [TW-2:0] cs[MAXC];
  logic [TW-2:0] cr[MAXC];
  int            rel = REL_INF;
  int            entry = 0;
  int            loadn = 0;

  logic [TW-2:0] want_settle = 7'd5;
  logic [TW-2:0] want_rqst   = 7'd20;
  bit            rand_cfg = 1'b0;

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  // Reference model for cycle t. Lines reach the filter two cycles after being
  // driven; the filter adopts a value once the last F samples agree; state
  // rules follow the protocol description with the timer seen as "cycles since
  // entry"; outputs show the previous cycle's state and transition.
  task automatic model(input int t);
    exp_t e;
    bit same;
    int cur, nxt, ev, age;
    bit trig;
    logic [1:0] f;
    e.c = t;
    if (t <= rel) begin
      sa[t] = 2'b11; fa[t] = 2'b11; sta[t] = M_STOP; eva[t] = E_NONE; entry = t;
      e.v = 9'b0_0_0_0_1_11_0_0;
      exp_q.push_back(e);
      return;
    end
    sa[t] = (t - 2 >= rel) ? pa[t-2] : 2'b11;
    same = 1'b1;
    for (int k = 2; k <= F; k++) if (sa[t-k] != sa[t-1]) same = 1'b0;
    fa[t] = same ? sa[t-1] : fa[t-1];
    cur = sta[t-1];
    f = fa[t-1];
    age = (t - 1) - entry;
    trig = (age >= loadn);
    nxt = cur;
    ev = E_NONE;
    case (cur)
      M_STOP:   if (f == 2'b01) nxt = M_RQST;
                else if (f != 2'b11) begin nxt = M_ERR; ev = E_SEQ; end
      M_RQST:   if (f == 2'b00) nxt = M_SETTLE;
                else if (f == 2'b11) nxt = M_STOP;
                else if (f == 2'b10) begin nxt = M_ERR; ev = E_SEQ; end
                else if (trig) begin nxt = M_ERR; ev = E_TO; end
      M_SETTLE: if (trig) begin nxt = M_HS; ev = E_START; end
                else if (f != 2'b00) begin nxt = M_ERR; ev = E_SEQ; end
      M_HS:     if (f == 2'b11) begin nxt = M_STOP; ev = E_END; end
                else if (f != 2'b00) begin nxt = M_ERR; ev = E_SEQ; end
      default:  if (f == 2'b11) nxt = M_STOP;
    endcase
    if (nxt != cur) begin
      entry = t;
      if (nxt == M_RQST) loadn = int'(cr[t-1]);
      if (nxt == M_SETTLE) loadn = int'(cs[t-1]);
    end
    sta[t] = nxt;
    eva[t] = ev;
    e.v = {(sta[t-1] == M_SETTLE) || (sta[t-1] == M_HS), sta[t-1] == M_HS,
           eva[t-1] == E_START, eva[t-1] == E_END, sta[t-1] == M_STOP, fa[t],
           eva[t-1] == E_SEQ, eva[t-1] == E_TO};
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [1:0] v);
    lp_dp = v[1];
    lp_dn = v[0];
    if (rand_cfg && $urandom_range(0, 15) == 0) want_settle = 7'($urandom_range(0, 12));
    if (rand_cfg && $urandom_range(0, 15) == 0) want_rqst = 7'($urandom_range(0, 30));
    cfg_settle = want_settle;
    cfg_rqst_max = want_rqst;
    cs[cyc] = want_settle;
    cr[cyc] = want_rqst;
    pa[cyc] = v;
  endtask

  task automatic step(input logic [1:0] v, input bit release_rst);
    @(posedge clk);
    #1;
    drive(v);
    if (release_rst) begin
      rel = cyc;
      rst_n = 1'b1;
    end
    model(cyc);
  endtask

  task automatic seg(input logic [1:0] v, input int n);
    for (int i = 0; i < n; i++) step(v, 1'b0);
  endtask

  // Monitor: compares every cycle against the scoreboard and records edges.
  logic [8:0] dut_v;
  assign dut_v = {hs_term_en, hs_active, hs_start, hs_end, stop_state, lp_state, err_seq, err_timeout};
  logic prev_term = 1'b0, prev_act = 1'b0, prev_stop = 1'b1;
  int n_term = 0, n_act = 0, n_end = 0, n_seq = 0, n_to = 0, n_stopfall = 0;
  int t_term = -1, t_act = -1, t_start = -1, t_end = -1, t_to = -1, t_stopfall = -1;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      if (exp_q[0].c == cyc) begin
        checks++;
        if (dut_v !== exp_q[0].v) begin
          errors++;
          $display("FAIL scoreboard cycle %0d got %b want %b", cyc, dut_v, exp_q[0].v);
        end
        exp_q.delete(0);
      end else if (exp_q[0].c < cyc) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_stale cycle %0d got none want entry for %0d", cyc, exp_q[0].c);
        exp_q.delete(0);
      end
    end
    if (hs_term_en && !prev_term) begin n_term++; t_term = cyc; end
    if (hs_active && !prev_act) begin n_act++; t_act = cyc; end
    if (!stop_state && prev_stop) begin n_stopfall++; t_stopfall = cyc; end
    if (hs_start) t_start = cyc;
    if (hs_end) begin n_end++; t_end = cyc; end
    if (err_seq) n_seq++;
    if (err_timeout) begin n_to++; t_to = cyc; end
    prev_term = hs_term_en;
    prev_act = hs_active;
    prev_stop = stop_state;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c_edge, b_sf, b_seq, b_to, b_act, b_end;
    logic [1:0] cur_v, v;

    seg(2'b11, 3);
    step(2'b11, 1'b1);
    seg(2'b11, 6);

    // Nominal entry and exit.
    seg(2'b01, 10);
    seg(2'b00, 25);
    c_edge = cyc + 1;
    seg(2'b11, 12);
    chk("nominal_act_after_term", t_act - t_term, 6);
    chk("nominal_start_with_act", t_start, t_act);
    chk("nominal_end_latency", t_end - c_edge, 6);
    chk("nominal_stop", int'(stop_state), 1);

    // Glitch rejection, then a 2-cycle request that aborts silently.
    b_sf = n_stopfall; b_seq = n_seq; b_to = n_to; b_act = n_term;
    seg(2'b01, 1);
    seg(2'b11, 10);
    chk("glitch1_no_fsm_move", n_stopfall - b_sf, 0);
    chk("glitch1_lp_state", int'(lp_state), 3);
    seg(2'b01, 2);
    seg(2'b11, 10);
    chk("glitch2_fsm_moved", n_stopfall - b_sf, 1);
    chk("abort_no_error", (n_seq - b_seq) + (n_to - b_to), 0);
    chk("abort_no_term", n_term - b_act, 0);
    chk("abort_stop", int'(stop_state), 1);

    // Request timeout.
    b_to = n_to;
    seg(2'b01, 30);
    chk("timeout_latency", t_to - t_stopfall, 21);
    chk("timeout_count", n_to - b_to, 1);
    seg(2'b11, 10);
    chk("timeout_recover_stop", int'(stop_state), 1);

    // Illegal sequences.
    b_seq = n_seq;
    seg(2'b10, 6);
    seg(2'b11, 8);
    chk("seq_11_10", n_seq - b_seq, 1);
    b_seq = n_seq; b_act = n_act;
    seg(2'b01, 5);
    seg(2'b00, 3);
    seg(2'b11, 10);
    chk("seq_early_exit", n_seq - b_seq, 1);
    chk("seq_early_no_hs", n_act - b_act, 0);

    // Randomized segments, mostly following the legal order.
    rand_cfg = 1'b1;
    cur_v = 2'b11;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) < 7) begin
        case (cur_v)
          2'b11:   v = 2'b01;
          2'b01:   v = 2'b00;
          default: v = 2'b11;
        endcase
      end else begin
        v = 2'($urandom_range(0, 3));
      end
      seg(v, $urandom_range(1, 25));
      cur_v = v;
    end
    rand_cfg = 1'b0;
    want_settle = 7'd5;
    want_rqst = 7'd20;
    seg(2'b11, 12);

    // Asynchronous reset while in HS.
    seg(2'b01, 5);
    seg(2'b00, 15);
    chk("reset_pre_hs_active", int'(hs_active), 1);
    b_end = n_end;
    @(posedge clk);
    #1;
    drive(2'b00);
    model(cyc);
    #2;
    rst_n = 1'b0;
    rel = REL_INF;
    exp_q.delete();
    #1;
    chk("reset_hs_active_now", int'(hs_active), 0);
    chk("reset_term_now", int'(hs_term_en), 0);
    chk("reset_stop_now", int'(stop_state), 1);
    seg(2'b00, 3);
    step(2'b11, 1'b1);
    seg(2'b11, 10);
    chk("reset_no_hs_end", n_end - b_end, 0);
    chk("reset_release_stop", int'(stop_state), 1);
    chk("reset_release_lp", int'(lp_state), 3);

    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nano_dsi_clk_rx.md
Name: nano_dsi_clk_rx

Overview:
Receive-side D-PHY clock-lane controller for the nano-PMOD, i.e. the far end of our clock-lane transmitter. It samples the two LP-level comparator inputs (dp/dn) and tracks the LP-11 → LP-01 → LP-00 → HS entry sequence and the return to LP-11. It enables HS termination at the right time and tells the data-lane receivers when the HS clock is valid. Sequence violations and timeouts are reported as error pulses.

Parameters:
FILT_LEN, 2, consecutive identical synchronized samples required before the filtered LP state changes (1..15).
TIMER_W, 8, timer width; the timer MSB is the trigger bit.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
lp_dp  input  1  raw LP comparator, P line (asynchronous to clk)
lp_dn  input  1  raw LP comparator, N line (asynchronous to clk)
cfg_settle  input  TIMER_W-1  LP-00 settle time; load value (N gives N+1 cycles)
cfg_rqst_max  input  TIMER_W-1  maximum LP-01 duration; load value
hs_term_en  output  1  enable HS termination / HS receiver
hs_active  output  1  HS clock valid; data lanes may sample
hs_start  output  1  one-cycle pulse on entry to HS
hs_end  output  1  one-cycle pulse on return to stop state from HS
stop_state  output  1  lane in LP-11 stop state
lp_state  output  2  filtered {dp,dn}
err_seq  output  1  one-cycle pulse on an illegal LP transition
err_timeout  output  1  one-cycle pulse when LP-01 exceeds cfg_rqst_max

Behaviour:
- Reset (rst_n low, async): lp_f=2'b11, FSM=ST_STOP, stop_state=1, lp_state=2'b11, all other outputs 0. Reset mid-HS drops hs_active/hs_term_en immediately; there is no hs_end pulse.
- Input path: 2-flop synchronizer per line gives lp_s = {dp,dn}. A run counter holds how many consecutive cycles lp_s has stayed at its current value. lp_f <= lp_s once that count reaches FILT_LEN. Any change restarts the count, so glitches shorter than FILT_LEN are rejected.
- Pin edge to lp_f change: 2+FILT_LEN cycles. lp_f to FSM state: +1. All outputs are registered from the FSM: +1 more.
- Timer: TIMER_W bits, zero-extended load on state entry, decrements every cycle, trig = MSB. A load of N triggers N+1 cycles after entry.
- FSM (evaluated on lp_f):
  - ST_STOP: 01 → ST_HS_RQST, load cfg_rqst_max. 10 or 00 → ST_ERR with err_seq.
  - ST_HS_RQST: 00 → ST_SETTLE, load cfg_settle. 11 → ST_STOP, silent abort. 10 → ST_ERR with err_seq. trig → ST_ERR with err_timeout.
  - ST_SETTLE: trig → ST_HS. 11, 01 or 10 before trig → ST_ERR with err_seq.
  - ST_HS: 11 → ST_STOP with hs_end. 01 or 10 → ST_ERR with err_seq. 00 is normal (HS swing reads as LP-00).
  - ST_ERR: stays until lp_f=11, then → ST_STOP. No pulses while in ST_ERR.
- Output decoding:
  - hs_term_en = state ∈ {SETTLE, HS}
  - hs_active = state==HS
  - stop_state = state==STOP
  - hs_start on the cycle after entering HS
- Simultaneous events: in ST_HS_RQST an lp_f change takes priority over trig in the same cycle. Only one error pulse fires per transition.
- cfg_* inputs are sampled only at load, so changing them mid-count has no effect.

Decomposition:
- Shared package nano_dphy_pkg: LP codes (LP11=2'b11, LP01=2'b01, LP10=2'b10, LP00=2'b00) and clock-rx state localparams (ST_STOP, ST_HS_RQST, ST_SETTLE, ST_HS, ST_ERR).
- Sub-module nano_dphy_lp_filt: 2-line synchronizer plus FILT_LEN glitch filter. It is reused by the data-lane receivers.

Test Plan:
- Nominal entry (FILT_LEN=2, cfg_rqst_max=20, cfg_settle=5): 11 → 01 held 10 cycles → 00.
  - Required: hs_term_en rises with SETTLE.
  - Required: hs_active and hs_start rise 6 cycles after SETTLE entry.
  - Required: pins to 11 → hs_end pulse and stop_state=1, 2+2+1+1 cycles after the pin edge.
- Glitch rejection: a 1-cycle 01 pulse from 11 leaves lp_state=11 and the FSM in ST_STOP. A 2-cycle pulse moves the FSM to ST_HS_RQST.
- Timeout: hold 01 for 30 cycles with cfg_rqst_max=20 → one err_timeout pulse 21 cycles after entry, FSM in ST_ERR. Return to 11 → stop_state=1.
- Illegal sequence: 11 → 10 gives err_seq. 01 → 00 → 11 before the settle trig gives err_seq and no hs_active.
- Abort: 11 → 01 → 11 → back to ST_STOP with no error and no hs_term_en.
- Async reset: assert rst_n=0 while in ST_HS → hs_active=0 immediately, no hs_end. Release → stop_state=1, lp_state=11.
